puf_key_gen: RTL and testbench
==============================

# puf_key_gen

Challenge sequencer and key assembler that sits directly upstream and downstream of the ring-oscillator PUF core. On request it drives the core's `start`/`challenge` inputs through all 8 challenges and evaluates each challenge `VOTES` times. It majority-votes each 2-bit response and packs the results into a 16-bit device key with a stability flag. It is the only agent that drives the PUF core.

## Interface

- `EVAL_CYCLES`, default 256: cycles `puf_start` is held high per evaluation; must exceed the core counter's done latency; ≥1.
- `SETTLE_CYCLES`, default 4: cycles `puf_start` is held low between evaluations, so the core counter re-arms; ≥1.
- `VOTES`, default 3: evaluations per challenge; odd, ≥1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 1: start key generation; sampled only in IDLE.
- `busy` out 1: high from the cycle after `req` is accepted until completion.
- `key_valid` out 1: level; high from completion until the next accepted `req` or `rst`.
- `key` out 16: assembled key; `key[2c+1:2c]` is the majority response for challenge c.
- `unstable` out 1: set at completion if any response bit disagreed across votes; same validity as `key`.
- `puf_start` out 1: drives the core's `start`.
- `puf_challenge` out 3: drives the core's `challenge`.
- `puf_response` in 2: the core's latched response.

## Operation

- State machine: IDLE, EVAL, SAMPLE, GAP.
- IDLE
  - `busy`=0, `puf_start`=0.
  - `req`=1 → clear `key`, `unstable`, `key_valid`, vote counters; chal=0, vote=0 → EVAL.
- EVAL: `puf_start`=1 for exactly `EVAL_CYCLES` cycles (down-counter, width clog2(EVAL_CYCLES+1)), then → SAMPLE.
- SAMPLE
  - One cycle, `puf_start`=0.
  - For each bit i, increment ones[i] when `puf_response[i]`=1. ones[i] is clog2(VOTES+1) bits wide and saturation is never needed.
  - → GAP.
- GAP: `puf_start`=0 for `SETTLE_CYCLES` cycles. On the last GAP cycle:
  - vote<VOTES-1: vote++ → EVAL.
  - Otherwise resolve:
    - `key[2*chal+i]` ← (ones[i] > VOTES/2).
    - `unstable` ← `unstable` | (0<ones[i]<VOTES) for any i.
    - Clear ones and vote.
    - If chal=7: → IDLE, `key_valid`←1.
    - Else chal++ → EVAL.
- `puf_challenge` equals the chal register at all times. It changes only on the EVAL entry edge, never while `puf_start`=1.
- `req` while `busy`=1 is ignored (not queued).
- `key`/`unstable` hold stable while `key_valid`=1. Values seen while `busy`=1 are partial and not meaningful.

## Timing

- Reset values: `busy`=0, `key_valid`=0, `key`=16'h0000, `unstable`=0, `puf_start`=0, `puf_challenge`=3'd0; state IDLE.
- Let T=EVAL_CYCLES+1+SETTLE_CYCLES.
- `req` high at edge k (in IDLE):
  - `busy`=1 and `puf_start`=1 from cycle k+1.
  - `puf_start` falls after EVAL_CYCLES high cycles.
  - `puf_response` is sampled in the cycle after `puf_start` falls.
- `key_valid` rises and `busy` falls together at cycle k+1+8·VOTES·T.
- `req` held high continuously: it is re-accepted on the first IDLE cycle, one cycle after `key_valid` rises. `key_valid` then drops on the next edge.
- `rst` mid-operation: all outputs take their reset values on the next edge (`puf_start`=0 immediately) and partial votes are discarded. The next `req` restarts from challenge 0.
- `rst` and `req` together: `rst` wins.

## Test plan

- Reset, then idle 10 cycles → all outputs at reset values; `puf_start` never asserted.
- Behavioural PUF model returns `challenge[1:0]`; EVAL=8, SETTLE=2, VOTES=3; `req` pulse at cycle 0:
  - `key`=16'hE4E4, `unstable`=0.
  - `key_valid` rises at cycle 1+8·3·11=265.
  - `puf_challenge` steps 0..7, constant while `puf_start`=1.
- Same model except challenge 5 returns 11, 01, 11 across its votes → `key`=16'hECE4 (`key[11:10]`=11), `unstable`=1.
- Pulse `req` during `busy` → no restart, completion timing unchanged. A later `req` → `key_valid`=0 and `key`=0 the next cycle, then regeneration gives the same key.
- Assert `rst` mid-EVAL of challenge 3 → next cycle `puf_start`=0, `busy`=0, `key`=0. A new `req` begins at `puf_challenge`=0 with full latency.
- VOTES=1, noisy model → exactly 8 evaluations, `unstable`=0, `key_valid` at cycle 1+8·11=89.

Source files
------------

// File: rtl/puf_key_gen.sv
// puf_key_gen: challenge sequencer and key assembler for the ring-oscillator PUF core.
// Steps through all 8 challenges, evaluates each one VOTES times, majority-votes the
// 2-bit responses into a 16-bit key and flags any bit that disagreed across votes.
module puf_key_gen #(
    parameter int EVAL_CYCLES   = 256,
    parameter int SETTLE_CYCLES = 4,
    parameter int VOTES         = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    output logic        busy,
    output logic        key_valid,
    output logic [15:0] key,
    output logic        unstable,
    output logic        puf_start,
    output logic [2:0]  puf_challenge,
    input  logic [1:0]  puf_response
);

    // One down-counter times both EVAL and GAP, so it is sized for the longer phase.
    localparam int CNT_MAX = (EVAL_CYCLES > SETTLE_CYCLES) ? EVAL_CYCLES : SETTLE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int OW      = $clog2(VOTES + 1);
    localparam int VW      = (VOTES > 1) ? $clog2(VOTES) : 1;

    localparam logic [CW-1:0] EVAL_LOAD   = CW'(EVAL_CYCLES);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [OW-1:0] ONES_ALL    = OW'(VOTES);
    localparam logic [OW-1:0] ONES_HALF   = OW'(VOTES / 2);
    localparam logic [VW-1:0] VOTE_LAST   = VW'(VOTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVAL,
        ST_SAMPLE,
        ST_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      chal_q, chal_d;
    logic [VW-1:0]   vote_q, vote_d;
    logic [OW-1:0]   ones0_q, ones0_d;
    logic [OW-1:0]   ones1_q, ones1_d;
    logic [15:0]     key_q, key_d;
    logic            unstable_q, unstable_d;
    logic            key_valid_q, key_valid_d;

    // State register and datapath flops; rst has priority over everything, including req.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            chal_q      <= '0;
            vote_q      <= '0;
            ones0_q     <= '0;
            ones1_q     <= '0;
            key_q       <= '0;
            unstable_q  <= 1'b0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            chal_q      <= chal_d;
            vote_q      <= vote_d;
            ones0_q     <= ones0_d;
            ones1_q     <= ones1_d;
            key_q       <= key_d;
            unstable_q  <= unstable_d;
            key_valid_q <= key_valid_d;
        end
    end

    // Next-state logic: evaluate, sample, settle, and resolve votes on the last GAP cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        chal_d      = chal_q;
        vote_d      = vote_q;
        ones0_d     = ones0_q;
        ones1_d     = ones1_q;
        key_d       = key_q;
        unstable_d  = unstable_q;
        key_valid_d = key_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    key_d       = '0;
                    unstable_d  = 1'b0;
                    key_valid_d = 1'b0;
                    ones0_d     = '0;
                    ones1_d     = '0;
                    chal_d      = '0;
                    vote_d      = '0;
                    cnt_d       = EVAL_LOAD;
                    state_d     = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_SAMPLE: begin
                ones0_d = ones0_q + OW'(puf_response[0]);
                ones1_d = ones1_q + OW'(puf_response[1]);
                cnt_d   = SETTLE_LOAD;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (cnt_q != CNT_ONE) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (vote_q != VOTE_LAST) begin
                    vote_d  = vote_q + VW'(1);
                    cnt_d   = EVAL_LOAD;
                    state_d = ST_EVAL;
                end else begin
                    key_d[{chal_q, 1'b0} +: 2] = {ones1_q > ONES_HALF, ones0_q > ONES_HALF};
                    unstable_d = unstable_q
                               | ((ones0_q != '0) && (ones0_q != ONES_ALL))
                               | ((ones1_q != '0) && (ones1_q != ONES_ALL));
                    ones0_d = '0;
                    ones1_d = '0;
                    vote_d  = '0;
                    if (chal_q == 3'd7) begin
                        key_valid_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        chal_d  = chal_q + 3'd1;
                        cnt_d   = EVAL_LOAD;
                        state_d = ST_EVAL;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        busy          = (state_q != ST_IDLE);
        puf_start     = (state_q == ST_EVAL);
        puf_challenge = chal_q;
        key           = key_q;
        unstable      = unstable_q;
        key_valid     = key_valid_q;
    end

endmodule

// File: tb/tb_puf_key_gen.sv
// tb_puf_key_gen: scoreboard bench for puf_key_gen with a behavioural PUF model.
// Instance dut3 uses VOTES=3, instance dut1 uses VOTES=1; both EVAL=8, SETTLE=2.
module tb_puf_key_gen;

    localparam int E = 8;
    localparam int S = 2;
    localparam int T = E + 1 + S;
    localparam int BUDGET = 3000;

    typedef struct {
        logic [15:0] key;
        logic        unst;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst, req3, req1;
    logic busy3, key_valid3, unstable3, puf_start3;
    logic busy1, key_valid1, unstable1, puf_start1;
    logic [15:0] key3, key1;
    logic [2:0] pc3, pc1, pc_prev3, pc_prev1;
    logic [1:0] resp3, resp1;
    logic p3 = 1'b0, p1 = 1'b0;
    bit noisy3 = 1'b0;

    int errors = 0;
    int checks = 0;
    int vidx3[8];
    int vidx1[8];
    int chal_viol3 = 0;
    int chal_viol1 = 0;
    logic [2:0] log3[$];
    logic [2:0] log1[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    puf_key_gen #(.EVAL_CYCLES(E), .SETTLE_CYCLES(S), .VOTES(3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .busy(busy3), .key_valid(key_valid3),
        .key(key3), .unstable(unstable3), .puf_start(puf_start3),
        .puf_challenge(pc3), .puf_response(resp3)
    );

    puf_key_gen #(.EVAL_CYCLES(E), .SETTLE_CYCLES(S), .VOTES(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .busy(busy1), .key_valid(key_valid1),
        .key(key1), .unstable(unstable1), .puf_start(puf_start1),
        .puf_challenge(pc1), .puf_response(resp1)
    );

    // PUF model: response is challenge[1:0]; in noisy mode challenge 5 answers 11,01,11.
    function automatic logic [1:0] model(input logic [2:0] ch, input int v, input bit noisy);
        if (noisy && ch == 3'd5) begin
            case (v)
                1:       return 2'b11;
                2:       return 2'b01;
                default: return 2'b11;
            endcase
        end
        return ch[1:0];
    endfunction

    assign resp3 = model(pc3, vidx3[pc3], noisy3);
    assign resp1 = model(pc1, vidx1[pc1], 1'b1);

    // Track evaluations per challenge and challenge stability while start is high.
    always @(posedge clk) begin
        if (rst || (req3 && !busy3)) begin
            foreach (vidx3[i]) vidx3[i] <= 0;
            log3.delete();
        end else if (puf_start3 && !p3) begin
            vidx3[pc3] <= vidx3[pc3] + 1;
            log3.push_back(pc3);
        end
        if (p3 && puf_start3 && pc3 != pc_prev3) chal_viol3 <= chal_viol3 + 1;
        p3       <= puf_start3;
        pc_prev3 <= pc3;
    end

    always @(posedge clk) begin
        if (rst || (req1 && !busy1)) begin
            foreach (vidx1[i]) vidx1[i] <= 0;
            log1.delete();
        end else if (puf_start1 && !p1) begin
            vidx1[pc1] <= vidx1[pc1] + 1;
            log1.push_back(pc1);
        end
        if (p1 && puf_start1 && pc1 != pc_prev1) chal_viol1 <= chal_viol1 + 1;
        p1       <= puf_start1;
        pc_prev1 <= pc1;
    end

    task automatic test_reset;
        int start_seen;
        start_seen = 0;
        rst = 1'b1; req3 = 1'b0; req1 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (puf_start3 || puf_start1) start_seen++;
        end
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy3); end
        checks++; if (key_valid3 !== 1'b0) begin errors++; $display("FAIL reset_key_valid: got %0b expected 0", key_valid3); end
        checks++; if (key3 !== 16'h0000) begin errors++; $display("FAIL reset_key: got %h expected 0000", key3); end
        checks++; if (unstable3 !== 1'b0) begin errors++; $display("FAIL reset_unstable: got %0b expected 0", unstable3); end
        checks++; if (pc3 !== 3'd0) begin errors++; $display("FAIL reset_challenge: got %0d expected 0", pc3); end
        checks++; if (start_seen !== 0) begin errors++; $display("FAIL reset_start: got %0d start cycles expected 0", start_seen); end
        checks++; if (key_valid1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL reset_dut1: got kv=%0b busy=%0b expected 0 0", key_valid1, busy1); end
    endtask

    // One full key generation on the selected instance, optionally pulsing req while busy.
    task automatic test_gen(input bit use1, input logic [15:0] ek, input logic eu,
                            input int pulse_at, input string nm);
        exp_t e, got;
        int n, bad, votes, nlog;
        logic kv;
        votes = use1 ? 1 : 3;
        e.key = ek; e.unst = eu; e.lat = 1 + 8 * votes * T;
        @(negedge clk);
        if (use1) req1 = 1'b1; else req3 = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        req1 = 1'b0; req3 = 1'b0; n = 1;
        checks++; if ((use1 ? busy1 : busy3) !== 1'b1) begin errors++; $display("FAIL %s_busy_rise: got 0 expected 1", nm); end
        checks++; if ((use1 ? puf_start1 : puf_start3) !== 1'b1) begin errors++; $display("FAIL %s_start_rise: got 0 expected 1", nm); end
        checks++; if ((use1 ? key_valid1 : key_valid3) !== 1'b0) begin errors++; $display("FAIL %s_kv_clear: got 1 expected 0", nm); end
        checks++; if ((use1 ? key1 : key3) !== 16'h0000) begin errors++; $display("FAIL %s_key_clear: got %h expected 0000", nm, use1 ? key1 : key3); end
        checks++; if ((use1 ? pc1 : pc3) !== 3'd0) begin errors++; $display("FAIL %s_first_chal: got %0d expected 0", nm, use1 ? pc1 : pc3); end
        kv = use1 ? key_valid1 : key_valid3;
        while (!kv && n < BUDGET) begin
            @(negedge clk);
            n++;
            req3 = (!use1 && n == pulse_at);
            kv = use1 ? key_valid1 : key_valid3;
        end
        req3 = 1'b0;
        got = sb.pop_front();
        checks++; if (kv !== 1'b1) begin errors++; $display("FAIL %s_timeout: key_valid not seen in %0d cycles", nm, BUDGET); end
        checks++; if (n != got.lat) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", nm, n, got.lat); end
        checks++; if ((use1 ? key1 : key3) !== got.key) begin errors++; $display("FAIL %s_key: got %h expected %h", nm, use1 ? key1 : key3, got.key); end
        checks++; if ((use1 ? unstable1 : unstable3) !== got.unst) begin errors++; $display("FAIL %s_unstable: got %0b expected %0b", nm, use1 ? unstable1 : unstable3, got.unst); end
        checks++; if ((use1 ? busy1 : busy3) !== 1'b0) begin errors++; $display("FAIL %s_busy_fall: got 1 expected 0", nm); end
        nlog = use1 ? log1.size() : log3.size();
        bad = 0;
        for (int i = 0; i < nlog; i++) begin
            if ((use1 ? log1[i] : log3[i]) !== 3'(i / votes)) bad++;
        end
        checks++; if (nlog != 8 * votes) begin errors++; $display("FAIL %s_eval_count: got %0d expected %0d", nm, nlog, 8 * votes); end
        checks++; if (bad != 0) begin errors++; $display("FAIL %s_chal_order: got %0d out-of-order evaluations expected 0", nm, bad); end
        checks++; if ((use1 ? chal_viol1 : chal_viol3) != 0) begin errors++; $display("FAIL %s_chal_stable: got %0d changes while start high expected 0", nm, use1 ? chal_viol1 : chal_viol3); end
        repeat (3) @(negedge clk);
        checks++; if ((use1 ? key1 : key3) !== got.key || (use1 ? key_valid1 : key_valid3) !== 1'b1) begin
            errors++; $display("FAIL %s_hold: got key=%h kv=%0b expected key=%h kv=1", nm, use1 ? key1 : key3, use1 ? key_valid1 : key_valid3, got.key);
        end
    endtask

    task automatic test_req_held;
        int n;
        @(negedge clk);
        req3 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!key_valid3 && n < BUDGET);
        checks++; if (n != 1 + 24 * T) begin errors++; $display("FAIL held_latency: got %0d expected %0d", n, 1 + 24 * T); end
        checks++; if (key3 !== 16'hE4E4) begin errors++; $display("FAIL held_key: got %h expected e4e4", key3); end
        @(negedge clk);
        checks++; if (key_valid3 !== 1'b0 || busy3 !== 1'b1) begin
            errors++; $display("FAIL held_reaccept: got kv=%0b busy=%0b expected kv=0 busy=1", key_valid3, busy3);
        end
        req3 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_rst_mid;
        int n;
        @(negedge clk);
        req3 = 1'b1;
        @(negedge clk);
        req3 = 1'b0;
        n = 0;
        while (!(pc3 == 3'd3 && puf_start3) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n >= BUDGET) begin errors++; $display("FAIL rst_wait_chal3: got timeout expected challenge 3 eval"); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        req3 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req3 = 1'b0;
        checks++; if (puf_start3 !== 1'b0) begin errors++; $display("FAIL rst_start: got %0b expected 0", puf_start3); end
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", busy3); end
        checks++; if (key3 !== 16'h0000) begin errors++; $display("FAIL rst_key: got %h expected 0000", key3); end
        checks++; if (pc3 !== 3'd0) begin errors++; $display("FAIL rst_chal: got %0d expected 0", pc3); end
        test_gen(1'b0, 16'hE4E4, 1'b0, 0, "after_rst");
    endtask

    initial begin
        rst = 1'b1; req3 = 1'b0; req1 = 1'b0;
        test_reset;
        test_gen(1'b0, 16'hE4E4, 1'b0, 0, "basic");
        noisy3 = 1'b1;
        test_gen(1'b0, 16'hECE4, 1'b1, 0, "noisy");
        noisy3 = 1'b0;
        test_gen(1'b0, 16'hE4E4, 1'b0, 100, "req_busy");
        repeat (5) @(negedge clk);
        test_gen(1'b0, 16'hE4E4, 1'b0, 0, "regen");
        test_req_held;
        test_rst_mid;
        test_gen(1'b1, 16'hECE4, 1'b0, 0, "votes1");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
